// File: rtl/accum_sequencer_if.sv
// Sample-accept and result handshake bundle between the accumulation
// sequencer and its upstream source / downstream consumer.
interface accum_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/accum_sequencer.sv
// Frame controller for the complex accumulation unit: clears it, gates its
// clock-enable over N_SAMPLES accepted samples, captures and hands off the sum.
module accum_sequencer #(
  parameter int N_SAMPLES = 16,
  parameter int CNT_W     = $clog2(N_SAMPLES)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               abort,
  accum_sequencer_if.slave   bus,
  output logic               acc_ce,
  output logic               acc_clr_n,
  input  logic [31:0]        acc_val,
  output logic               busy,
  output logic [CNT_W-1:0]   smp_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_OUT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(N_SAMPLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [31:0]        data_q, data_nxt;
  logic               ready;
  logic               ce;
  logic               clr_n;
  logic               valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      smp_cnt <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      smp_cnt <= cnt_nxt;
      data_q  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = smp_cnt;
    data_nxt  = data_q;
    ready     = 1'b0;
    ce        = 1'b0;
    clr_n     = 1'b1;
    valid     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clr_n     = 1'b0;
        cnt_nxt   = '0;
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        // abort masks ready so the sample in the abort cycle never reaches acc
        ready = !abort;
        ce    = ready && bus.in_valid;
        if (ce) begin
          if (smp_cnt == LAST_SMP) begin
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt = smp_cnt + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        data_nxt  = acc_val;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // abort overrides every transition; the last captured result is kept
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      data_nxt  = data_q;
    end
  end

  // accumulator is held clear for as long as this block is in reset
  assign acc_clr_n     = clr_n && nrst;
  assign acc_ce        = ce;
  assign busy          = (state != S_IDLE);
  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboarded bench for accum_sequencer with a two-lane 16-bit accumulator model.
module tb_accum_sequencer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        abort;
  logic [31:0] in_data;
  logic [31:0] acc;
  logic        acc_ce;
  logic        acc_clr_n;
  logic        busy;
  logic [1:0]  smp_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] kept = '0;

  accum_sequencer_if bus();

  accum_sequencer #(.N_SAMPLES(N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .acc_ce    (acc_ce),
    .acc_clr_n (acc_clr_n),
    .acc_val   (acc),
    .busy      (busy),
    .smp_cnt   (smp_cnt)
  );

  always #5 clk = ~clk;

  // complex accumulator: independent 16-bit re/im lanes, sync clear
  always_ff @(posedge clk) begin
    if (!acc_clr_n)  acc <= '0;
    else if (acc_ce) acc <= {acc[31:16] + in_data[31:16], acc[15:0] + in_data[15:0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(output bit clr_seen);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    clr_seen = (acc_clr_n === 1'b0) && (busy === 1'b1) && (bus.in_ready === 1'b0);
    tick();
  endtask

  task automatic feed(input logic [31:0] d, input bit gaps,
                      output int acc_n, output int ce_n, output int cnt_err);
    logic [15:0] re, im;
    int k;
    re = '0; im = '0; k = 0;
    acc_n = 0; ce_n = 0; cnt_err = 0;
    while (acc_n < N && k < 40) begin
      bus.in_valid = gaps ? (k % 2 == 0) : 1'b1;
      in_data = d;
      #1;
      if (acc_ce === 1'b1) ce_n++;
      if (bus.in_valid) begin
        if (smp_cnt !== 2'(acc_n)) cnt_err++;
        re += d[31:16];
        im += d[15:0];
        acc_n++;
      end
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    if (acc_n == N) sb.push_back({re, im});
  endtask

  task automatic drain(output logic v_drain, output logic v_out);
    #1;
    v_drain = bus.out_valid;
    tick();
    v_out = bus.out_valid;
  endtask

  task automatic test_reset();
    bit c;
    int a, e, ce;
    nrst = 1'b0; start = 1'b0; abort = 1'b0; in_data = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #3;
    n_checks++; if ({busy, bus.in_ready, acc_ce, acc_clr_n, bus.out_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 00000", {busy, bus.in_ready, acc_ce, acc_clr_n, bus.out_valid}); end
    n_checks++; if (bus.out_data !== 32'h0 || smp_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_regs: data %h cnt %0d exp 0/0", bus.out_data, smp_cnt); end
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    tick();
    n_checks++; if (acc_clr_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: clr_n %b busy %b exp 1/0", acc_clr_n, busy); end
    kick(c);
    bus.in_valid = 1'b1; in_data = 32'h0003_0003;
    tick(); tick();
    #2;
    n_checks++; if (smp_cnt !== 2'd2 || acc_ce !== 1'b1) begin
      n_fail++; $display("FAIL mid_accum: cnt %0d ce %b exp 2/1", smp_cnt, acc_ce); end
    nrst = 1'b0;
    #1;
    n_checks++; if ({busy, bus.in_ready, acc_ce, acc_clr_n, bus.out_valid} !== 5'b0 || smp_cnt !== 2'd0 || bus.out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_frame: ctrl %b cnt %0d data %h exp 00000/0/0",
        {busy, bus.in_ready, acc_ce, acc_clr_n, bus.out_valid}, smp_cnt, bus.out_data); end
    bus.in_valid = 1'b0;
    tick();
    #2 nrst = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_partial_result: busy %b valid %b exp 0/0", busy, bus.out_valid); end
    a = 0; e = 0; ce = 0;
  endtask

  task automatic test_basic();
    bit c;
    int a, ce, e;
    logic vd, vo;
    logic [31:0] exp;
    kick(c);
    n_checks++; if (!c) begin n_fail++; $display("FAIL basic_clear: got 0 exp 1"); end
    feed(32'h0001_0002, 1'b0, a, ce, e);
    n_checks++; if (ce !== N || e !== 0) begin
      n_fail++; $display("FAIL basic_ce: ce_cycles %0d cnt_err %0d exp %0d/0", ce, e, N); end
    drain(vd, vo);
    n_checks++; if (vd !== 1'b0 || vo !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: drain %b out %b exp 0/1", vd, vo); end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL basic_data: scoreboard empty"); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp || exp !== 32'h0004_0008) begin
        n_fail++; $display("FAIL basic_data: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_handoff: valid %b busy %b exp 0/0", bus.out_valid, busy); end
  endtask

  task automatic test_gaps();
    bit c;
    int a, ce, e;
    logic vd, vo;
    logic [31:0] exp;
    kick(c);
    feed(32'h0001_0002, 1'b1, a, ce, e);
    n_checks++; if (a !== N || ce !== N || e !== 0) begin
      n_fail++; $display("FAIL gaps_count: accepts %0d ce %0d cnt_err %0d exp %0d/%0d/0", a, ce, e, N, N); end
    drain(vd, vo);
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0 || vo !== 1'b1) begin n_fail++; $display("FAIL gaps_data: valid %b queue %0d exp 1/>0", vo, sb.size()); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp) begin n_fail++; $display("FAIL gaps_data: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit c;
    int a, ce, e, bad;
    logic vd, vo;
    logic [31:0] exp;
    kick(c);
    feed(32'h0010_0001, 1'b0, a, ce, e);
    drain(vd, vo);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      #1;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0] ||
          bus.in_ready !== 1'b0 || acc_ce !== 1'b0 || smp_cnt !== 2'd0) bad++;
      tick();
    end
    start = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: bad_cycles %0d exp 0", bad); end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL bp_data: scoreboard empty"); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp) begin n_fail++; $display("FAIL bp_data: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: busy %b exp 0", busy); end
  endtask

  task automatic test_abort();
    bit c;
    int a, ce, e;
    logic vd, vo;
    logic [31:0] exp;
    kick(c);
    bus.in_valid = 1'b1; in_data = 32'h0005_0005;
    tick(); tick();
    abort = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || acc_ce !== 1'b0) begin
      n_fail++; $display("FAIL abort_mask: ready %b ce %b exp 0/0", bus.in_ready, acc_ce); end
    tick();
    abort = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || smp_cnt !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== kept) begin
      n_fail++; $display("FAIL abort_state: busy %b cnt %0d valid %b data %h exp 0/0/0/%h",
        busy, smp_cnt, bus.out_valid, bus.out_data, kept); end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_wins: busy %b exp 0", busy); end
    kick(c);
    feed(32'h0001_0001, 1'b0, a, ce, e);
    drain(vd, vo);
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL abort_fresh: scoreboard empty"); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp || exp !== 32'h0004_0004) begin
        n_fail++; $display("FAIL abort_fresh: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit c;
    int a, ce, e;
    logic vd, vo;
    logic [31:0] exp;
    kick(c);
    feed(32'h0002_0003, 1'b0, a, ce, e);
    drain(vd, vo);
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_first: scoreboard empty"); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
    kick(c);
    n_checks++; if (!c) begin n_fail++; $display("FAIL b2b_clear: got 0 exp 1"); end
    feed(32'h0001_0001, 1'b0, a, ce, e);
    drain(vd, vo);
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (sb.size() == 0 || vo !== 1'b1) begin n_fail++; $display("FAIL b2b_second: valid %b queue %0d exp 1/>0", vo, sb.size()); end
    else begin
      exp = sb.pop_front(); kept = exp;
      if (bus.out_data !== exp) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", bus.out_data, exp); end
    end
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d left exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
